part_cmd_ctrl: RTL and testbench

PART_CMD_CTRL -- requirements
Module: part_cmd_ctrl

---
 rtl/part_cmd_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_part_cmd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/part_cmd_ctrl.sv
// UART-driven command controller for part pins, scan chains, clock and reset.
// Define PART_CMD_ACK_EN to send 'k' after every completed command except 'r'.
module part_cmd_ctrl #(
  parameter int NPIS    = 14,
  parameter int NPOS    = 11,
  parameter int NCHAINS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [NPIS-1:0]    part_pis_o,
  input  logic [NPOS-1:0]    part_pos_i,
  output logic               scan_en,
  output logic [NCHAINS-1:0] scan_in,
  input  logic [NCHAINS-1:0] scan_out,
  output logic               part_clk_en,
  output logic               part_rst,
  output logic               busy
);

  localparam logic [7:0] C_R = 8'h72;
  localparam logic [7:0] C_S = 8'h73;
  localparam logic [7:0] C_G = 8'h67;
  localparam logic [7:0] C_I = 8'h69;
  localparam logic [7:0] C_O = 8'h6F;
  localparam logic [7:0] C_E = 8'h65;
  localparam logic [7:0] C_F = 8'h66;
  localparam logic [7:0] C_P = 8'h70;

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, S_RX, G_SCAN, G_TX, I_RX,
    O_TX, EXEC, FREE, RST_HOLD, RST_TX, ACK_TX
  } state_e;

`ifdef PART_CMD_ACK_EN
  localparam state_e DONE = ACK_TX;
`else
  localparam state_e DONE = IDLE;
`endif

  state_e              state_q;
  logic [7:0]          cmd_q;
  logic [15:0]         cnt_q;
  logic [15:0]         idx_q;
  logic [7:0]          cap_q;
  logic                txh_q;
  logic                tx_start_q;
  logic [7:0]          tx_data_q;
  logic [NPIS-1:0]     pis_q;
  logic                scan_en_q;
  logic [NCHAINS-1:0]  scan_in_q;
  logic                clk_en_q;
  logic                part_rst_q;

  logic [15:0] cnt_d;
  logic [7:0]  tx_byte_d;
  logic        pos_bit_d;
  logic        tx_st_d;
  logic        tx_done_d;

  assign cnt_d     = {cnt_q[15:8], rx_data};
  assign tx_st_d   = (state_q == G_TX) || (state_q == O_TX) ||
                     (state_q == RST_TX) || (state_q == ACK_TX);
  assign tx_done_d = tx_st_d && txh_q && !tx_ready;

  always_comb begin
    pos_bit_d = 1'b0;
    for (int b = 0; b < NPOS; b++)
      if (idx_q == 16'(b)) pos_bit_d = part_pos_i[b];
  end

  always_comb begin
    tx_byte_d = 8'h00;
    case (state_q)
      G_TX:    tx_byte_d = cap_q;
      O_TX:    tx_byte_d = 8'h30 | {7'd0, pos_bit_d};
      RST_TX:  tx_byte_d = (idx_q == 16'd0) ? 8'h4F :
                           (idx_q == 16'd1) ? 8'h4B : 8'h0A;
      ACK_TX:  tx_byte_d = 8'h6B;
      default: tx_byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      cap_q      <= '0;
      txh_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      pis_q      <= '0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= '0;
      clk_en_q   <= 1'b0;
      part_rst_q <= 1'b0;
    end else begin
      scan_en_q <= 1'b0;
      case (state_q)
        IDLE: if (rx_valid) begin
          cmd_q <= rx_data;
          unique case (1'b1)
            rx_data == C_R: begin
              part_rst_q <= 1'b1;
              pis_q      <= '0;
              cnt_q      <= 16'd16;
              state_q    <= RST_HOLD;
            end
            rx_data == C_S, rx_data == C_G, rx_data == C_I,
            rx_data == C_O, rx_data == C_E:
              state_q <= CNT_HI;
            rx_data == C_F: begin
              clk_en_q <= 1'b1;
              state_q  <= FREE;
            end
            default: ;
          endcase
        end
        CNT_HI: if (rx_valid) begin
          cnt_q[15:8] <= rx_data;
          state_q     <= CNT_LO;
        end
        CNT_LO: if (rx_valid) begin
          cnt_q <= cnt_d;
          idx_q <= '0;
          if (cnt_d == 16'd0) state_q <= IDLE;
          else begin
            unique case (1'b1)
              cmd_q == C_S: state_q <= S_RX;
              cmd_q == C_I: state_q <= I_RX;
              cmd_q == C_O: state_q <= O_TX;
              cmd_q == C_G: begin
                scan_en_q <= 1'b1;
                state_q   <= G_SCAN;
              end
              cmd_q == C_E: begin
                clk_en_q <= 1'b1;
                state_q  <= EXEC;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        S_RX: if (rx_valid) begin
          scan_in_q <= rx_data[NCHAINS-1:0];
          scan_en_q <= 1'b1;
          cnt_q     <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= DONE;
        end
        G_SCAN: begin
          cap_q   <= 8'h30 | 8'(scan_out);
          state_q <= G_TX;
        end
        G_TX: if (tx_done_d) begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= DONE;
          else begin
            scan_en_q <= 1'b1;
            state_q   <= G_SCAN;
          end
        end
        I_RX: if (rx_valid) begin
          for (int b = 0; b < NPIS; b++)
            if (idx_q == 16'(b)) pis_q[b] <= rx_data[0];
          idx_q <= idx_q + 16'd1;
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= DONE;
        end
        O_TX: if (tx_done_d) begin
          idx_q <= idx_q + 16'd1;
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_q <= DONE;
        end
        EXEC: begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            clk_en_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        FREE: if (rx_valid && rx_data == C_P) begin
          clk_en_q <= 1'b0;
          state_q  <= DONE;
        end
        RST_HOLD: begin
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            part_rst_q <= 1'b0;
            idx_q      <= '0;
            state_q    <= RST_TX;
          end
        end
        RST_TX: if (tx_done_d) begin
          idx_q <= idx_q + 16'd1;
          if (idx_q == 16'd2) state_q <= IDLE;
        end
        ACK_TX: if (tx_done_d) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // launch only on tx_ready, release once the UART has gone busy
      if (tx_st_d) begin
        if (!txh_q) begin
          if (tx_ready) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= tx_byte_d;
            txh_q      <= 1'b1;
          end
        end else if (!tx_ready) begin
          tx_start_q <= 1'b0;
          txh_q      <= 1'b0;
        end
      end
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign part_pis_o  = pis_q;
  assign scan_en     = scan_en_q;
  assign scan_in     = scan_in_q;
  assign part_clk_en = clk_en_q;
  assign part_rst    = rst | part_rst_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_part_cmd_ctrl.sv
// Randomized bench for part_cmd_ctrl with a transaction-level reference model.
// Honours PART_CMD_ACK_EN when the design is built with it.
module tb_part_cmd_ctrl;
  localparam int NPIS = 14;
  localparam int NPOS = 11;
  localparam int NCH  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic [NPIS-1:0] part_pis_o;
  logic [NPOS-1:0] part_pos_i;
  logic            scan_en;
  logic [NCH-1:0]  scan_in;
  logic [NCH-1:0]  scan_out;
  logic            part_clk_en;
  logic            part_rst;
  logic            busy;

  part_cmd_ctrl #(.NPIS(NPIS), .NPOS(NPOS), .NCHAINS(NCH)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .part_pis_o(part_pis_o), .part_pos_i(part_pos_i),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .part_clk_en(part_clk_en), .part_rst(part_rst), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0]     got_tx[$];
  logic [7:0]     exp_tx[$];
  logic [7:0]     pay[$];
  logic [NCH-1:0] scan_log[$];
  logic [NCH-1:0] exp_scan[$];
  int clk_cnt, clk_rise, rst_cnt, viol = 0;
  int exp_clk, exp_rst, exp_scan_n;
  logic clk_prev = 1'b0;
  logic [NPIS-1:0] m_pis = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (part_clk_en) clk_cnt++;
      if (part_clk_en && !clk_prev) clk_rise++;
      if (scan_en) scan_log.push_back(scan_in);
      if (part_rst) rst_cnt++;
      if (scan_en && part_clk_en) viol++;
    end
    clk_prev = part_clk_en;
  end

  // UART transmitter model with random busy time
  initial begin
    int lat;
    lat = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && tx_ready) begin
        got_tx.push_back(tx_data);
        tx_ready = 1'b0;
        lat = $urandom_range(1, 4);
      end else if (!tx_ready) begin
        lat--;
        if (lat <= 0) tx_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int at);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    at = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 4000; t++) begin
      if (!busy) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", busy, 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_tx.delete(); exp_tx.delete();
    scan_log.delete(); exp_scan.delete();
    clk_cnt = 0; clk_rise = 0; rst_cnt = 0;
    exp_clk = 0; exp_rst = 0; exp_scan_n = 0;
  endtask

  task automatic add_ack();
`ifdef PART_CMD_ACK_EN
    exp_tx.push_back(8'h6B);
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_txn"}, got_tx.size(), exp_tx.size());
    for (int k = 0; k < exp_tx.size() && k < got_tx.size(); k++)
      chk({tag, "_txb"}, got_tx[k], exp_tx[k]);
    chk({tag, "_pis"}, part_pis_o, m_pis);
    chk({tag, "_clk"}, clk_cnt, exp_clk);
    chk({tag, "_rise"}, clk_rise, (exp_clk != 0) ? 1 : 0);
    chk({tag, "_scann"}, scan_log.size(), exp_scan_n);
    for (int k = 0; k < exp_scan.size() && k < scan_log.size(); k++)
      chk({tag, "_scand"}, scan_log[k], exp_scan[k]);
    chk({tag, "_prst"}, rst_cnt, exp_rst);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // pay holds the n data bytes for 's' and 'i'
  task automatic do_cmd(input logic [7:0] c, input int n, input string tag);
    int at;
    bit counted;
    clear_mon();
    counted = (c == "s" || c == "g" || c == "i" || c == "o" || c == "e");
    case (c)
      "e": exp_clk = n;
      "s": begin
        for (int j = 0; j < n; j++) exp_scan.push_back(pay[j][NCH-1:0]);
        exp_scan_n = n;
      end
      "g": begin
        for (int j = 0; j < n; j++)
          exp_tx.push_back(8'h30 | 8'(scan_out));
        exp_scan_n = n;
      end
      "i": for (int j = 0; j < n && j < NPIS; j++) m_pis[j] = pay[j][0];
      "o": for (int j = 0; j < n; j++)
        exp_tx.push_back(8'h30 | ((j < NPOS) ? 8'(part_pos_i[j]) : 8'h00));
      "r": begin
        exp_rst = 16;
        m_pis = '0;
        exp_tx.push_back(8'h4F);
        exp_tx.push_back(8'h4B);
        exp_tx.push_back(8'h0A);
      end
      default: ;
    endcase
    if (counted && n != 0) add_ack();
    send_byte(c, at);
    if (counted) begin
      send_byte(8'(n >> 8), at);
      send_byte(8'(n), at);
      if (c == "s" || c == "i")
        for (int j = 0; j < n; j++) send_byte(pay[j], at);
    end
    wait_idle();
    check_all(tag);
  endtask

  initial begin
    int a, b, n, sel;
    logic [7:0] c;
    string s;
    logic [7:0] junk [4];
    junk[0] = "x"; junk[1] = "p"; junk[2] = 8'h00; junk[3] = "k";

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    scan_out = '0; part_pos_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_txs", tx_start, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_pis", part_pis_o, 0);
    chk("rst_sen", scan_en, 0);
    chk("rst_sin", scan_in, 0);
    chk("rst_clk", part_clk_en, 0);
    chk("rst_prst", part_rst, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_prst", part_rst, 0);
    chk("post_busy", busy, 0);

    do_cmd("e", 4, "exec4");
    pay.delete(); pay.push_back(8'h31); pay.push_back(8'h32);
    do_cmd("s", 2, "scan2");
    scan_out = 2'b11;
    do_cmd("g", 1, "get1");
    chk("get1_byte", (got_tx.size() > 0) ? got_tx[0] : 8'h00, 8'h33);

    s = "1010101010111111";
    pay.delete();
    for (int k = 0; k < 16; k++) pay.push_back(s[k]);
    do_cmd("i", 16, "pis16");
    chk("pis16_val", part_pis_o, 14'b11110101010101);

    part_pos_i = 11'b00000000101;
    do_cmd("o", 3, "pos3");
    do_cmd("e", 0, "exec0");
    do_cmd("e", 256, "exec256");

    clear_mon();
    send_byte("f", a);
    repeat (50) @(negedge clk);
    send_byte("x", b);
    repeat (5) @(negedge clk);
    send_byte("p", b);
    add_ack();
    exp_clk = b - a;
    wait_idle();
    check_all("free");

    clear_mon();
    exp_clk = 30;
    add_ack();
    send_byte("e", a);
    send_byte(8'h00, a);
    send_byte(8'd30, a);
    send_byte("e", a);
    wait_idle();
    repeat (10) @(negedge clk);
    check_all("drop");

    do_cmd("r", 0, "reset_cmd");

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 7);
      scan_out = NCH'($urandom);
      part_pos_i = NPOS'($urandom);
      n = $urandom_range(0, 5);
      case (sel)
        0, 7: c = "e";
        1: c = "s";
        2: c = "g";
        3: begin c = "i"; n = $urandom_range(0, 18); end
        4: c = "o";
        5: c = "r";
        default: c = junk[$urandom_range(0, 3)];
      endcase
      pay.delete();
      for (int j = 0; j < n; j++) pay.push_back(8'($urandom));
      do_cmd(c, n, $sformatf("rnd%0d_%s", it, string'(c)));
    end

    clear_mon();
    scan_out = 2'b01;
    send_byte("g", a);
    send_byte(8'h00, a);
    send_byte(8'h05, a);
    n = 0;
    for (int t = 0; t < 2000; t++) begin
      if (got_tx.size() >= 2) begin n = 1; break; end
      @(negedge clk);
    end
    if (n == 0) chk("midrst_wait", got_tx.size(), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_txs", tx_start, 0);
    chk("midrst_sen", scan_en, 0);
    chk("midrst_pis", part_pis_o, 0);
    rst = 1'b0;
    m_pis = '0;
    repeat (200) @(negedge clk);
    chk("midrst_txn", got_tx.size(), 2);
    chk("midrst_b0", got_tx[0], 8'h31);
    chk("midrst_b1", got_tx[1], 8'h31);
    chk("midrst_idle", busy, 0);

    chk("overlap", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
